// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V main control unit.
// Holds the FSM state encoding, supported opcodes, ALUOp codes, datapath
// mux encodings, the registered control-word layout and its decoder.
package riscv_ctrl_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned SRC_W    = 2;

   // FSM states
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC      = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8
   } state_e;

   // Supported RV32I opcodes
   localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

   // ALUOp codes for the ALU control decoder
   localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'b10;

   // ALU operand A select
   localparam logic [SRC_W-1:0] SRCA_PC     = 2'b00;
   localparam logic [SRC_W-1:0] SRCA_OLD_PC = 2'b01;
   localparam logic [SRC_W-1:0] SRCA_RS1    = 2'b10;

   // ALU operand B select
   localparam logic [SRC_W-1:0] SRCB_RS2    = 2'b00;
   localparam logic [SRC_W-1:0] SRCB_FOUR   = 2'b01;
   localparam logic [SRC_W-1:0] SRCB_IMM    = 2'b10;

   // PC source select
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // Per-state control word. The last three fields are qualifiers that the
   // top combines with mem_ready / opcode for the few non-Moore strobes.
   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic [SRC_W-1:0]   alu_src_a;
      logic [SRC_W-1:0]   alu_src_b;
      logic               pc_source;
      logic               iord;
      logic               mem_read;
      logic               mem_write;
      logic               pc_write_cond;
      logic               reg_write;
      logic               mem_to_reg;
      logic               retired;
      logic               in_fetch;
      logic               in_decode;
      logic               in_store;
   } ctrl_t;

   // True for the opcodes this control unit knows how to sequence
   function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Moore decode: control word as a pure function of state
   function automatic ctrl_t ctrl_decode(input state_e s);
      ctrl_t c;
      c               = '0;
      c.alu_op        = ALUOP_ADD;
      c.alu_src_a     = SRCA_PC;
      c.alu_src_b     = SRCB_RS2;
      c.pc_source     = PCSRC_ALU;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.in_fetch  = 1'b1;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut here
            c.alu_src_a = SRCA_OLD_PC;
            c.alu_src_b = SRCB_IMM;
            c.in_decode = 1'b1;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            c.mem_read  = 1'b1;
            c.iord      = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.retired    = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            c.in_store  = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNC;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.retired   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = SRCA_RS1;
            c.alu_src_b     = SRCB_RS2;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
            c.retired       = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (R-type, load, store,
// branch). Sequences fetch/decode/execute/memory/writeback and drives every
// datapath strobe and mux select.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   opcode[6:0]       instr[6:0] from the instruction register
//   mem_ready         memory completes the current access this cycle
//   zero              ALU zero flag (branch qualification happens outside)
//   alu_op[1:0]       ALUOp for the ALU control decoder
//   alu_src_a/b[1:0]  ALU operand selects
//   pc_source, iord, mem_to_reg                 mux selects
//   mem_read, mem_write, ir_write, pc_write,
//   pc_write_cond, reg_write                    datapath strobes
//   retired           pulse in the last cycle of each instruction
//   illegal           pulse in decode for an unsupported opcode
module multicycle_control
   import riscv_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                zero,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [SRC_W-1:0]    alu_src_a,
   output logic [SRC_W-1:0]    alu_src_b,
   output logic                pc_source,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                retired,
   output logic                illegal
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q;
   logic   strobe_en;

   // Zero flag is consumed by the external pc_write_cond gate, not here
   logic   zero_unused;
   assign  zero_unused = zero;

   // Next-state logic; opcode only matters in decode and mem-addr
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:          state_d = S_EXEC;
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_BRANCH:         state_d = S_BRANCH;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            case (opcode)
               OP_LOAD:  state_d = S_MEM_READ;
               OP_STORE: state_d = S_MEM_WRITE;
               default:  state_d = S_FETCH;
            endcase
         end
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_EXEC:      state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   // State register plus control word registered alongside it, so every
   // Moore output comes straight from a flop. Reset loads the fetch word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_decode(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_decode(state_d);
      end
   end

   // Strobes are masked while reset is held so an in-flight access or a
   // retire is dropped immediately rather than at the next edge.
   assign strobe_en     = ~reset;

   assign alu_op        = ctrl_q.alu_op;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign pc_source     = ctrl_q.pc_source;
   assign iord          = ctrl_q.iord;
   assign mem_to_reg    = ctrl_q.mem_to_reg;

   assign mem_read      = ctrl_q.mem_read      & strobe_en;
   assign mem_write     = ctrl_q.mem_write     & strobe_en;
   assign pc_write_cond = ctrl_q.pc_write_cond & strobe_en;
   assign reg_write     = ctrl_q.reg_write     & strobe_en;

   // Fetch completes in the mem_ready cycle itself
   assign ir_write      = ctrl_q.in_fetch & mem_ready & strobe_en;
   assign pc_write      = ctrl_q.in_fetch & mem_ready & strobe_en;

   // Store retires in its mem_ready cycle; other paths retire by state
   assign retired       = (ctrl_q.retired | (ctrl_q.in_store & mem_ready))
                          & strobe_en;

   assign illegal       = ctrl_q.in_decode & ~op_supported(opcode) & strobe_en;

endmodule
